// File: rtl/dffram_nr1w_if.sv
// Bus bundle for the dffram_nr1w register file.
// Carries the write port (w_en/w_addr/w_mask/w_data) and the global
// write-through enable wt_en. It also carries the packed read ports
// (r_addr/r_buf/r_data), the clear request/status (clr_req/busy) and
// the out-of-range write flag (w_oob).
// master: the block that drives writes and reads (user / testbench).
// slave : the register file itself.
interface dffram_nr1w_if #(
  parameter int AWIDTH = 5,
  parameter int LANES  = 2,
  parameter int LWIDTH = 4,
  parameter int NREAD  = 2
);
  localparam int WWIDTH = LANES * LWIDTH;

  logic                      w_en;
  logic [AWIDTH-1:0]         w_addr;
  logic [LANES-1:0]          w_mask;
  logic [WWIDTH-1:0]         w_data;
  logic                      wt_en;
  logic [NREAD*AWIDTH-1:0]   r_addr;
  logic [NREAD-1:0]          r_buf;
  logic [NREAD*WWIDTH-1:0]   r_data;
  logic                      clr_req;
  logic                      busy;
  logic                      w_oob;

  modport master (
    output w_en, w_addr, w_mask, w_data, wt_en, r_addr, r_buf, clr_req,
    input  r_data, busy, w_oob
  );

  modport slave (
    input  w_en, w_addr, w_mask, w_data, wt_en, r_addr, r_buf, clr_req,
    output r_data, busy, w_oob
  );
endinterface

// File: rtl/dffram_nr1w.sv
// dffram_nr1w: flip-flop register file, one lane-masked write port and
// NREAD read ports. Each read port selects combinational or registered
// output at run time.
// Features:
//   - address-compare write-through bypass (wt_en)
//   - zero data for out-of-range addresses (>= DEPTH)
//   - a sequential clear engine that zeroes storage one word per cycle,
//     after reset (CLEAR_ON_RESET) or on clr_req
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (control state and read buffers)
//   bus    dffram_nr1w_if.slave (write port, read ports, clear, flags)
module dffram_nr1w #(
  parameter int AWIDTH         = 5,
  parameter int DEPTH          = 24,
  parameter int LANES          = 2,
  parameter int LWIDTH         = 4,
  parameter int NREAD          = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  dffram_nr1w_if.slave  bus
);
  localparam int WWIDTH = LANES * LWIDTH;
  localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST    = AWIDTH'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

  state_e              state_q;
  logic [AWIDTH-1:0]   clr_ptr_q;
  logic                w_oob_q;
  logic                w_oob_d;
  logic [WWIDTH-1:0]   mem_q  [DEPTH];
  logic [WWIDTH-1:0]   rbuf_q [NREAD];
  logic [WWIDTH-1:0]   rd_word[NREAD];
  logic [AWIDTH-1:0]   ra     [NREAD];
  logic [NREAD-1:0]    r_in_rng;
  logic                busy_w;
  logic                w_in_rng;
  logic                w_accept;
  logic                wr_ok;

  assign busy_w   = (state_q == CLEAR);
  assign w_in_rng = ({1'b0, bus.w_addr} < DEPTH_W);
  // A clear request in IDLE wins over a write in the same cycle.
  assign w_accept = bus.w_en && !busy_w && !bus.clr_req;
  assign wr_ok    = w_accept && w_in_rng;
  assign w_oob_d  = w_accept && !w_in_rng;

  genvar gp;
  generate
    for (gp = 0; gp < NREAD; gp++) begin : g_port
      assign ra[gp]       = bus.r_addr[gp*AWIDTH +: AWIDTH];
      assign r_in_rng[gp] = ({1'b0, ra[gp]} < DEPTH_W);
      assign bus.r_data[gp*WWIDTH +: WWIDTH] = bus.r_buf[gp] ? rbuf_q[gp] : rd_word[gp];
    end
  endgenerate

  assign bus.busy  = busy_w;
  assign bus.w_oob = w_oob_q;

  // Combinational read word per port, with write-through lane overlay.
  always_comb begin
    for (int p = 0; p < NREAD; p++) begin
      rd_word[p] = '0;
      if (!busy_w && r_in_rng[p]) begin
        rd_word[p] = mem_q[ra[p]];
        if (bus.wt_en && bus.w_en && w_in_rng && (ra[p] == bus.w_addr)) begin
          for (int l = 0; l < LANES; l++) begin
            if (bus.w_mask[l]) begin
              rd_word[p][l*LWIDTH +: LWIDTH] = bus.w_data[l*LWIDTH +: LWIDTH];
            end
          end
        end
      end
    end
  end

  // Clear FSM and out-of-range flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_ptr_q <= '0;
      w_oob_q   <= 1'b0;
    end else begin
      w_oob_q <= w_oob_d;
      case (state_q)
        IDLE: begin
          if (bus.clr_req) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
          end
        end
        CLEAR: begin
          // clr_req is ignored here; the sweep never restarts.
          if (clr_ptr_q == LAST) begin
            state_q <= IDLE;
          end else begin
            clr_ptr_q <= clr_ptr_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read buffers capture the combinational word every cycle.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NREAD; p++) begin
      if (!rst_n) begin
        rbuf_q[p] <= '0;
      end else begin
        rbuf_q[p] <= rd_word[p];
      end
    end
  end

  // Storage: no reset; a reset edge leaves partially cleared words as they are.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (busy_w) begin
        mem_q[clr_ptr_q] <= '0;
      end else if (wr_ok) begin
        for (int l = 0; l < LANES; l++) begin
          if (bus.w_mask[l]) begin
            mem_q[bus.w_addr][l*LWIDTH +: LWIDTH] <= bus.w_data[l*LWIDTH +: LWIDTH];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_dffram_nr1w.sv
module tb_dffram_nr1w;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  dffram_nr1w_if #(.AWIDTH(5), .LANES(2), .LWIDTH(4), .NREAD(2)) bus ();

  dffram_nr1w #(
    .AWIDTH(5), .DEPTH(24), .LANES(2), .LWIDTH(4), .NREAD(2), .CLEAR_ON_RESET(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       w_en;
    logic [4:0] w_addr;
    logic [1:0] w_mask;
    logic [7:0] w_data;
    logic       wt_en;
    logic [4:0] ra0;
    logic [4:0] ra1;
    logic [1:0] rbuf;
    logic [7:0] exp0;
    logic [7:0] exp1;
    logic       exp_oob;
  } vec_t;

  vec_t vecs [18];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.w_en    = 1'b0;
    bus.w_addr  = '0;
    bus.w_mask  = '0;
    bus.w_data  = '0;
    bus.wt_en   = 1'b0;
    bus.clr_req = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    bus.r_buf = 2'b00;
    for (int a = 0; a < 24; a++) begin
      bus.r_addr = {5'(23 - a), 5'(a)};
      #1;
      chk({tag, "_p0"}, 32'(bus.r_data[7:0]), 32'h0);
      chk({tag, "_p1"}, 32'(bus.r_data[15:8]), 32'h0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    //             w_en w_addr mask  data   wt   ra0    ra1    rbuf   exp0   exp1   oob
    vecs[0]  = '{1'b1, 5'd3,  2'b11, 8'hA5, 1'b0, 5'd3,  5'd3,  2'b00, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 5'd3,  2'b01, 8'h0F, 1'b0, 5'd3,  5'd3,  2'b00, 8'hA5, 8'hA5, 1'b0};
    vecs[2]  = '{1'b1, 5'd3,  2'b00, 8'h00, 1'b0, 5'd3,  5'd3,  2'b00, 8'hAF, 8'hAF, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  2'b00, 8'h00, 1'b0, 5'd3,  5'd3,  2'b00, 8'hAF, 8'hAF, 1'b0};
    vecs[4]  = '{1'b1, 5'd7,  2'b11, 8'h12, 1'b0, 5'd7,  5'd6,  2'b00, 8'h00, 8'h00, 1'b0};
    vecs[5]  = '{1'b1, 5'd7,  2'b10, 8'h3C, 1'b1, 5'd7,  5'd6,  2'b00, 8'h32, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, 5'd0,  2'b00, 8'h00, 1'b0, 5'd7,  5'd7,  2'b00, 8'h32, 8'h32, 1'b0};
    vecs[7]  = '{1'b1, 5'd7,  2'b11, 8'h55, 1'b0, 5'd0,  5'd7,  2'b10, 8'h00, 8'h32, 1'b0};
    vecs[8]  = '{1'b0, 5'd0,  2'b00, 8'h00, 1'b0, 5'd0,  5'd7,  2'b10, 8'h00, 8'h32, 1'b0};
    vecs[9]  = '{1'b0, 5'd0,  2'b00, 8'h00, 1'b0, 5'd0,  5'd7,  2'b10, 8'h00, 8'h55, 1'b0};
    vecs[10] = '{1'b0, 5'd0,  2'b00, 8'h00, 1'b0, 5'd0,  5'd7,  2'b00, 8'h00, 8'h55, 1'b0};
    vecs[11] = '{1'b1, 5'd5,  2'b11, 8'h9C, 1'b1, 5'd5,  5'd5,  2'b11, 8'h00, 8'h55, 1'b0};
    vecs[12] = '{1'b0, 5'd0,  2'b00, 8'h00, 1'b0, 5'd5,  5'd5,  2'b11, 8'h9C, 8'h9C, 1'b0};
    vecs[13] = '{1'b0, 5'd0,  2'b00, 8'h00, 1'b0, 5'd3,  5'd3,  2'b00, 8'hAF, 8'hAF, 1'b0};
    vecs[14] = '{1'b1, 5'd30, 2'b11, 8'hFF, 1'b0, 5'd30, 5'd6,  2'b00, 8'h00, 8'h00, 1'b0};
    vecs[15] = '{1'b1, 5'd30, 2'b11, 8'hFF, 1'b1, 5'd30, 5'd6,  2'b00, 8'h00, 8'h00, 1'b1};
    vecs[16] = '{1'b0, 5'd0,  2'b00, 8'h00, 1'b0, 5'd30, 5'd6,  2'b00, 8'h00, 8'h00, 1'b1};
    vecs[17] = '{1'b0, 5'd0,  2'b00, 8'h00, 1'b0, 5'd6,  5'd3,  2'b00, 8'h00, 8'hAF, 1'b0};

    // Reset with both ports buffered.
    rst_n = 1'b0;
    idle_inputs();
    bus.r_addr = {5'd1, 5'd0};
    bus.r_buf  = 2'b11;
    step();
    step();
    chk("rst_busy", 32'(bus.busy), 32'h1);
    chk("rst_oob", 32'(bus.w_oob), 32'h0);
    chk("rst_rdata_buf", 32'(bus.r_data), 32'h0);
    bus.r_buf = 2'b00;
    #1;
    chk("rst_rdata_comb", 32'(bus.r_data), 32'h0);

    // Power-up sweep: busy through the 24th edge after release.
    rst_n = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      chk($sformatf("init_busy_%0d", i), 32'(bus.busy), 32'(i < 24));
    end
    read_all_zero("init_rd");

    // Directed vectors: comparisons taken before each edge.
    for (int v = 0; v < 18; v++) begin
      bus.w_en   = vecs[v].w_en;
      bus.w_addr = vecs[v].w_addr;
      bus.w_mask = vecs[v].w_mask;
      bus.w_data = vecs[v].w_data;
      bus.wt_en  = vecs[v].wt_en;
      bus.r_addr = {vecs[v].ra1, vecs[v].ra0};
      bus.r_buf  = vecs[v].rbuf;
      #1;
      chk($sformatf("v%0d_p0", v), 32'(bus.r_data[7:0]), 32'(vecs[v].exp0));
      chk($sformatf("v%0d_p1", v), 32'(bus.r_data[15:8]), 32'(vecs[v].exp1));
      chk($sformatf("v%0d_oob", v), 32'(bus.w_oob), 32'(vecs[v].exp_oob));
      chk($sformatf("v%0d_busy", v), 32'(bus.busy), 32'h0);
      step();
    end
    idle_inputs();

    // clr_req together with a write to addr 2: write dropped, sweep starts.
    bus.clr_req = 1'b1;
    bus.w_en    = 1'b1;
    bus.w_addr  = 5'd2;
    bus.w_mask  = 2'b11;
    bus.w_data  = 8'h77;
    step();
    idle_inputs();
    chk("clr_busy_start", 32'(bus.busy), 32'h1);
    chk("clr_oob", 32'(bus.w_oob), 32'h0);
    for (int i = 1; i <= 9; i++) step();
    chk("clr_busy_mid", 32'(bus.busy), 32'h1);

    // Reset at sweep cycle 10 restarts the sweep.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_busy", 32'(bus.busy), 32'h1);
    for (int i = 1; i <= 24; i++) begin
      // clr_req held early must not restart; writes while busy are dropped.
      bus.clr_req = (i <= 10);
      bus.w_en    = (i >= 12 && i <= 14);
      bus.w_addr  = (i == 14) ? 5'd30 : 5'd4;
      bus.w_mask  = 2'b11;
      bus.w_data  = 8'hEE;
      step();
      chk($sformatf("resweep_busy_%0d", i), 32'(bus.busy), 32'(i < 24));
    end
    idle_inputs();
    chk("resweep_oob", 32'(bus.w_oob), 32'h0);
    read_all_zero("final_rd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dffram_nr1w.md
# dffram_nr1w

Parametrised flip-flop register file with one lane-masked write port and NREAD independent read ports. Each read port is individually switchable between combinational and registered output. The block adds a real address-compare write-through bypass, defined out-of-range behaviour for non-power-of-two depths, and a sequential clear engine that zeroes storage after reset or on request. It is the next-generation storage primitive for the DFF RAM tiles and sits between the pin-mux/config logic and the user-facing data pins.

## Interface
- AWIDTH, 5: address width.
- DEPTH, 24: words implemented, 1..2^AWIDTH; addresses >= DEPTH are out of range.
- LANES, 2: write lanes per word.
- LWIDTH, 4: bits per lane; WWIDTH = LANES*LWIDTH.
- NREAD, 2: number of read ports.
- CLEAR_ON_RESET, 1: 1 = run a clear sweep after reset.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- w_en  in  1  write strobe.
- w_addr  in  AWIDTH  write address.
- w_mask  in  LANES  lane enables; bit i covers w_data[i*LWIDTH +: LWIDTH].
- w_data  in  WWIDTH  write word.
- wt_en  in  1  write-through bypass enable, global.
- r_addr  in  NREAD*AWIDTH  read address; port p uses slice p.
- r_buf  in  NREAD  per-port mode: 1 = registered, 0 = combinational.
- r_data  out  NREAD*WWIDTH  read data; port p uses slice p.
- clr_req  in  1  start clear sweep.
- busy  out  1  clear sweep in progress.
- w_oob  out  1  registered pulse: previous cycle's write was out of range.

## Operation
- Storage is DEPTH x WWIDTH flops with no reset. Only the clear engine initialises it.
- Write: when w_en=1, busy=0 and w_addr<DEPTH, each lane with w_mask[i]=1 is updated at the clock edge. Lanes with w_mask[i]=0 keep their value. w_mask=0 performs no write.
- Write with w_addr>=DEPTH: storage is unchanged and w_oob=1 for the next cycle.
- Combinational read word for port p, called cw[p]:
  - r_addr[p]>=DEPTH: all zeros.
  - busy=1: all zeros.
  - Otherwise mem[r_addr[p]].
  - Bypass: when wt_en=1, w_en=1, busy=0 and r_addr[p]==w_addr<DEPTH, the lanes enabled in w_mask show w_data; the other lanes show the stored data.
- Read buffer: every cycle, rbuf[p] <= cw[p], regardless of r_buf.
- Output: r_data[p] = r_buf[p] ? rbuf[p] : cw[p].
- Clear FSM has two states, IDLE and CLEAR, with counter clr_ptr (AWIDTH bits).
  - rst_n=0: next state is CLEAR if CLEAR_ON_RESET=1, else IDLE. clr_ptr<=0, all rbuf<=0, w_oob<=0.
  - IDLE with clr_req=1: go to CLEAR, clr_ptr<=0. A write in the same cycle is dropped, because clr_req has priority.
  - CLEAR: each cycle mem[clr_ptr]<=0 and clr_ptr increments. When clr_ptr==DEPTH-1, zero that word and go to IDLE.
  - clr_req while in CLEAR is ignored; it does not restart the sweep.
- busy = (state==CLEAR). Writes and bypass are suppressed while busy. w_oob is not raised for writes issued while busy.

## Timing
- Values at reset (rst_n=0 at an edge):
  - busy = CLEAR_ON_RESET.
  - w_oob = 0.
  - rbuf = 0.
  - r_data = 0 on any port where r_buf=1. On other ports r_data = cw, which is 0 while busy.
- Clear sweep takes exactly DEPTH cycles. For DEPTH=24: with CLEAR_ON_RESET=1, busy is high from the reset edge through the 24th edge after rst_n rises, then low.
- If rst_n is asserted mid-sweep, the sweep restarts from clr_ptr=0 (or goes to IDLE if CLEAR_ON_RESET=0). Partially cleared contents stay as they are.
- Write lands on edge N:
  - Unbuffered read of that address sees the new data after edge N. With bypass active, it sees the new data in cycle N itself.
  - Buffered read sees the new data after edge N+1. With bypass active, it sees it after edge N.
- Read latency: 0 cycles combinational, 1 cycle registered. Switching r_buf takes effect immediately (mux select).
- w_oob is high for exactly one cycle per out-of-range write edge.
- Two ports with equal addresses return identical data.

## Test plan
- Reset with CLEAR_ON_RESET=1, DEPTH=24 -> busy=1 for 24 cycles after rst_n rises. Then all 24 addresses read 0x00 on both ports.
- Lane mask: write 0xA5 to addr 3 with mask 11, then 0x0F with mask 01 -> addr 3 reads 0xAF. Writing mask 00 leaves it at 0xAF.
- Bypass: addr 7 holds 0x12; set wt_en=1 and write 0x3C mask 10 to addr 7, with port0 r_buf=0 reading addr 7 -> port0 shows 0x32 in the write cycle. Port1 reading addr 6 is unaffected.
- Buffered read: port1 r_buf=1 reads addr 7 after it was written with 0x55 -> the old value is seen for one cycle, then 0x55. Switching to r_buf=0 shows 0x55 combinationally.
- Out of range: write 0xFF to addr 30 (DEPTH=24) -> w_oob=1 for one cycle, addr 30 reads 0x00, addr 6 (alias of 30 mod 24) is unchanged.
- Mid-operation: raise clr_req with w_en=1 to addr 2, then assert rst_n=0 at sweep cycle 10 for one cycle -> the write is dropped, busy stays high for 24 more cycles, and all addresses end at 0x00.
